rancnet_input_sequencer: RTL and testbench
==========================================

# rancnet_input_sequencer

Upstream feeder for the 1x1 RANC network grid: buffers 30-bit spike packets written by the host and drains them into the grid's west input through the grid's empty/read-enable handshake. Drives the grid's `tick` once per frame, after all packets of that frame have been consumed and the grid reports it is ready. Frames are delimited by marker entries written into the same FIFO, so the host can run ahead of the grid by up to `DEPTH` entries.

## Interface
- `DEPTH`, 512, FIFO entries (packets plus markers); power of two.
- `PACKET_WIDTH`, 30, packet width; matches the grid `packet_in` width (dx 9, dy 9, axon 8, tick delay 4).
- `TICK_GAP`, 4, cycles after a tick pulse during which `tick_ready` is ignored.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  host write strobe.
- `wr_marker`  in  1  with `wr_en`: write an end-of-frame marker; `wr_data` is ignored.
- `wr_data`  in  PACKET_WIDTH  packet to enqueue.
- `start`  in  1  pulse: begin running `num_ticks` frames.
- `num_ticks`  in  16  frame count, sampled on `start`.
- `packet_out`  out  PACKET_WIDTH  FIFO head; connects to grid `packet_in`.
- `buffer_empty`  out  1  connects to grid `input_buffer_empty`.
- `ren`  in  1  from grid `ren_to_input_buffer`.
- `tick`  out  1  one-cycle tick pulse to the grid.
- `tick_ready`  in  1  from the grid.
- `wait_packets`  in  1  from the grid.
- `fifo_full`  out  1  occupancy equals `DEPTH`.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse after the last tick's gap expires.
- `overflow_err`  out  1  sticky: a write was dropped.
- `underflow_err`  out  1  sticky: `ren` was asserted while `buffer_empty` was high.

## Operation
- FIFO entry width is PACKET_WIDTH+1; bit PACKET_WIDTH is the marker flag.
- Read is show-ahead: `packet_out` shows the head data bits and is 0 when the FIFO is empty.
- `buffer_empty` = !(state==FEED) | fifo_empty | head_is_marker. While a marker is at the head, the grid sees no packets.
- Pop on `ren & !buffer_empty`. `ren` while `buffer_empty` is high is ignored and sets `underflow_err`.
- Write is accepted when `!fifo_full`, judged on the registered count even if a pop happens in the same cycle. Otherwise the write is dropped and `overflow_err` is set.
- FSM states:
  - IDLE: on `start` with `num_ticks`≠0, load `remaining` and go to FEED. `start` with 0 pulses `done` and stays in IDLE. `start` in any other state is ignored.
  - FEED: if the head is a marker and `tick_ready & !wait_packets`, the FSM pops the marker, asserts `tick` for one cycle, decrements `remaining` and goes to GAP. An empty FIFO means stay in FEED (host starvation is legal).
  - GAP: count `TICK_GAP` cycles, then go to FEED if `remaining`≠0, else go to IDLE with `done` pulsed.
- Packets written with no following marker are fed to the grid but never cause a tick.
- Reset mid-operation:
  - FIFO is flushed and pointers and count are cleared.
  - FSM goes to IDLE.
  - Sticky errors are cleared.

## Timing
- Reset values:
  - `packet_out`=0, `buffer_empty`=1, `tick`=0, `fifo_full`=0, `fifo_count`=0.
  - `busy`=0, `done`=0, both error flags 0.
- A write in cycle N is visible at the head and reflected in `fifo_count` in cycle N+1.
- A pop in cycle N shows the next head in cycle N+1.
- Marker at head with the grid ready: `tick` is high in the next cycle, and the marker has left the head in that same cycle.
- Minimum spacing between ticks is TICK_GAP+2 cycles.
- `done` follows the final tick by TICK_GAP+1 cycles.
- Simultaneous push and pop when not full: count is unchanged and both operations take effect.
- Pointers wrap modulo DEPTH.

## Structure
- The shared `ranc_pkg` holds the state encoding, the `PACKET_WIDTH` default and the marker bit index.
- One sub-module, `ranc_sync_fifo`: show-ahead, width and depth parameterised, with count, full and empty outputs.
- The FSM, gap counter and `remaining` counter live in the top module.

## Test plan
- Write 3 packets then a marker, `start` with num_ticks=1, grid holds `ren`=1 with tick_ready=1. Required: 3 pops in consecutive cycles, then `buffer_empty`=1, one `tick` pulse, and `done` TICK_GAP+1 cycles later.
- Write marker, marker, and `start` with num_ticks=2. Required: two ticks spaced exactly TICK_GAP+2 cycles apart, and zero pops seen by the grid.
- Marker at head with wait_packets=1 for 10 cycles. Required: no tick, marker retained, tick the cycle after wait_packets falls.
- Fill to DEPTH=512, then one more write. Required: `fifo_full`=1, `overflow_err`=1, count stays 512. A write and pop in the same cycle while full leaves the count at 511.
- Grid asserts `ren` on an empty FIFO. Required: no pointer change and `underflow_err`=1. Async `reset` mid-FEED gives all outputs at their reset values and `busy`=0 immediately.

Source files
------------

// File: rtl/ranc_pkg.sv
// Shared types and constants for the RANC network input feeder.
// Holds the FSM encoding, default packet width and marker flag index.
package ranc_pkg;

  localparam int RANC_PACKET_WIDTH = 30;
  localparam int RANC_MARKER_BIT = RANC_PACKET_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ranc_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module ranc_sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [WIDTH-1:0] wdata,
  input  logic          pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push_ok;
  logic pop_ok;

  assign full = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10: count_d = count_q + 1'b1;
      2'b01: count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; flushed by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rancnet_input_sequencer.sv
// Host-to-grid spike packet feeder with frame markers.
// Drains packets to the grid and issues one tick per frame.
module rancnet_input_sequencer
  import ranc_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int PACKET_WIDTH = RANC_PACKET_WIDTH,
  parameter int TICK_GAP = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_marker,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  input  logic                    start,
  input  logic [15:0]             num_ticks,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    buffer_empty,
  input  logic                    ren,
  output logic                    tick,
  input  logic                    tick_ready,
  input  logic                    wait_packets,
  output logic                    fifo_full,
  output logic [CW-1:0]           fifo_count,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int GW = $clog2(TICK_GAP + 2);
  localparam int EW = PACKET_WIDTH + 1;

  seq_state_e state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [GW-1:0] gap_q, gap_d;
  logic tick_q, tick_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;
  logic fifo_empty;
  logic head_marker;
  logic grid_pop;
  logic marker_pop;

  assign fifo_wdata = wr_marker ? {1'b1, {PACKET_WIDTH{1'b0}}}
                                : {1'b0, wr_data};

  ranc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .wdata (fifo_wdata),
    .pop   (grid_pop | marker_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_marker = ~fifo_empty & fifo_rdata[PACKET_WIDTH];
  assign buffer_empty = (state_q != FEED) | fifo_empty | head_marker;
  assign packet_out = fifo_empty ? '0 : fifo_rdata[PACKET_WIDTH-1:0];
  assign grid_pop = ren & ~buffer_empty;

  assign tick = tick_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign overflow_err = ovf_q;
  assign underflow_err = udf_q;

  // Frame FSM: feed packets, tick on a marker, then hold off the grid.
  always_comb begin
    state_d = state_q;
    remaining_d = remaining_q;
    gap_d = gap_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    marker_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_ticks != 16'd0) begin
            remaining_d = num_ticks;
            state_d = FEED;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (head_marker & tick_ready & ~wait_packets) begin
          marker_pop = 1'b1;
          tick_d = 1'b1;
          remaining_d = remaining_q - 16'd1;
          gap_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        // The tick cycle plus TICK_GAP ignored cycles.
        if (gap_q == GW'(TICK_GAP)) begin
          if (remaining_q != 16'd0) begin
            state_d = FEED;
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags for dropped writes and reads of an empty buffer.
  always_comb begin
    ovf_d = ovf_q | (wr_en & fifo_full);
    udf_d = udf_q | (ren & buffer_empty);
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      remaining_q <= '0;
      gap_q <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      gap_q <= gap_d;
      tick_q <= tick_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule

// File: tb/tb_rancnet_input_sequencer.sv
// Directed bench for rancnet_input_sequencer.
// Vector table for one frame plus hand-written corner sequences.
module tb_rancnet_input_sequencer;

  localparam int PW = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic wr_marker = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic start = 1'b0;
  logic [15:0] num_ticks = '0;
  logic [PW-1:0] packet_out;
  logic buffer_empty;
  logic ren = 1'b0;
  logic tick;
  logic tick_ready = 1'b0;
  logic wait_packets = 1'b0;
  logic fifo_full;
  logic [9:0] fifo_count;
  logic busy;
  logic done;
  logic overflow_err;
  logic underflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  rancnet_input_sequencer #(
    .DEPTH (512),
    .PACKET_WIDTH (PW),
    .TICK_GAP (4)
  ) dut (
    .clk (clk),
    .reset (reset),
    .wr_en (wr_en),
    .wr_marker (wr_marker),
    .wr_data (wr_data),
    .start (start),
    .num_ticks (num_ticks),
    .packet_out (packet_out),
    .buffer_empty (buffer_empty),
    .ren (ren),
    .tick (tick),
    .tick_ready (tick_ready),
    .wait_packets (wait_packets),
    .fifo_full (fifo_full),
    .fifo_count (fifo_count),
    .busy (busy),
    .done (done),
    .overflow_err (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr_en;
    logic wr_marker;
    logic [PW-1:0] wr_data;
    logic start;
    logic [15:0] num_ticks;
    logic ren;
    logic tick_ready;
    logic [PW-1:0] e_pkt;
    logic e_be;
    logic e_tick;
    logic [9:0] e_cnt;
    logic e_busy;
    logic e_done;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0;
    wr_marker = 1'b0;
    wr_data = '0;
    start = 1'b0;
    num_ticks = '0;
    ren = 1'b0;
    tick_ready = 1'b0;
    wait_packets = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_word(input logic mk, input logic [PW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_marker = mk;
    wr_data = d;
  endtask

  localparam logic [PW-1:0] PA = 30'h1234567;
  localparam logic [PW-1:0] PB = 30'h3FFFFFFF;
  localparam logic [PW-1:0] PC = 30'h0000001;

  initial begin
    int t1, t2, td, nt, pops, errs;
    logic [PW-1:0] want;

    // wr, mk, data, st, nt, ren, rdy | pkt, be, tick, cnt, busy, done
    vecs[0]  = '{1,0,PA,0,0,0,0, 0, 1,0,0,0,0};
    vecs[1]  = '{1,0,PB,0,0,0,0, PA,1,0,1,0,0};
    vecs[2]  = '{1,0,PC,0,0,0,0, PA,1,0,2,0,0};
    vecs[3]  = '{1,1,0, 0,0,0,0, PA,1,0,3,0,0};
    vecs[4]  = '{0,0,0, 1,1,0,1, PA,1,0,4,0,0};
    vecs[5]  = '{0,0,0, 0,0,1,1, PA,0,0,4,1,0};
    vecs[6]  = '{0,0,0, 0,0,1,1, PB,0,0,3,1,0};
    vecs[7]  = '{0,0,0, 0,0,1,1, PC,0,0,2,1,0};
    vecs[8]  = '{0,0,0, 0,0,0,1, 0, 1,0,1,1,0};
    vecs[9]  = '{0,0,0, 0,0,0,1, 0, 1,1,0,1,0};
    vecs[10] = '{0,0,0, 0,0,0,1, 0, 1,0,0,1,0};
    vecs[11] = '{0,0,0, 0,0,0,1, 0, 1,0,0,1,0};
    vecs[12] = '{0,0,0, 0,0,0,1, 0, 1,0,0,1,0};
    vecs[13] = '{0,0,0, 0,0,0,1, 0, 1,0,0,1,0};
    vecs[14] = '{0,0,0, 0,0,0,1, 0, 1,0,0,0,1};
    vecs[15] = '{0,0,0, 0,0,0,1, 0, 1,0,0,0,0};

    // Reset values while reset is held.
    #12;
    chk("rst_pkt", 32'(packet_out), 0);
    chk("rst_be", 32'(buffer_empty), 1);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_udf", 32'(underflow_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // One frame of three packets, table driven.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_pkt", i), 32'(packet_out), 32'(vecs[i].e_pkt));
      chk($sformatf("v%0d_be", i), 32'(buffer_empty), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
      chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_udf", i), 32'(underflow_err), 0);
      wr_en = vecs[i].wr_en;
      wr_marker = vecs[i].wr_marker;
      wr_data = vecs[i].wr_data;
      start = vecs[i].start;
      num_ticks = vecs[i].num_ticks;
      ren = vecs[i].ren;
      tick_ready = vecs[i].tick_ready;
    end

    // Two back-to-back markers: tick spacing and done latency.
    reset_dut();
    push_word(1'b1, '0);
    push_word(1'b1, '0);
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    num_ticks = 16'd2;
    tick_ready = 1'b1;
    ren = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t1 = -1; t2 = -1; td = -1; nt = 0; pops = 0;
    for (int c = 0; c < 40; c++) begin
      if (tick) begin
        nt++;
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
      if (done && td < 0) td = c;
      if (ren && !buffer_empty) pops++;
      @(negedge clk);
    end
    chk("m2_ticks", nt, 2);
    chk("m2_spacing", t2 - t1, 6);
    chk("m2_done_lat", td - t2, 5);
    chk("m2_pops", pops, 0);
    chk("m2_busy", 32'(busy), 0);

    // Marker held off by wait_packets.
    reset_dut();
    push_word(1'b1, '0);
    @(negedge clk);
    clear_inputs();
    start = 1'b1;
    num_ticks = 16'd1;
    tick_ready = 1'b1;
    wait_packets = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("wp_noticks", nt, 0);
    chk("wp_cnt", 32'(fifo_count), 1);
    chk("wp_be", 32'(buffer_empty), 1);
    wait_packets = 1'b0;
    @(negedge clk);
    chk("wp_tick", 32'(tick), 1);
    chk("wp_cnt_after", 32'(fifo_count), 0);

    // Fill, overflow, push+pop while full, wrap and drain.
    reset_dut();
    for (int i = 0; i < 512; i++) push_word(1'b0, PW'(i + 100));
    @(negedge clk);
    chk("full_flag", 32'(fifo_full), 1);
    chk("full_cnt", 32'(fifo_count), 512);
    chk("full_ovf0", 32'(overflow_err), 0);
    wr_data = 30'd999;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_flag", 32'(overflow_err), 1);
    chk("ovf_cnt", 32'(fifo_count), 512);
    start = 1'b1;
    num_ticks = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("feed_head", 32'(packet_out), 100);
    wr_en = 1'b1;
    wr_data = 30'd888;
    ren = 1'b1;
    @(negedge clk);
    chk("pp_cnt", 32'(fifo_count), 511);
    chk("pp_head", 32'(packet_out), 101);
    wr_data = 30'd777;
    ren = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("refill_cnt", 32'(fifo_count), 512);
    errs = 0;
    for (int k = 0; k < 512; k++) begin
      want = (k < 511) ? PW'(101 + k) : 30'd777;
      if (packet_out !== want) errs++;
      ren = 1'b1;
      @(negedge clk);
    end
    ren = 1'b0;
    chk("drain_order_errs", errs, 0);
    chk("drain_cnt", 32'(fifo_count), 0);
    chk("drain_be", 32'(buffer_empty), 1);
    chk("drain_udf", 32'(underflow_err), 0);

    // ren on a blocked buffer, then async reset mid-FEED.
    reset_dut();
    push_word(1'b0, 30'd5);
    @(negedge clk);
    wr_en = 1'b0;
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    chk("udf_flag", 32'(underflow_err), 1);
    chk("udf_cnt", 32'(fifo_count), 1);
    chk("udf_head", 32'(packet_out), 5);
    start = 1'b1;
    num_ticks = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1;
    wr_data = 30'd6;
    @(negedge clk);
    wr_en = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_cnt", 32'(fifo_count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pkt", 32'(packet_out), 0);
    chk("ar_be", 32'(buffer_empty), 1);
    chk("ar_tick", 32'(tick), 0);
    chk("ar_cnt", 32'(fifo_count), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_udf", 32'(underflow_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // start with zero frames pulses done and stays idle.
    start = 1'b1;
    num_ticks = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
